// File: rtl/demux4_pkg.sv
// Shared constants and types for the buffered 1-to-4 demultiplexer.
package demux4_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    // Destination channel select carried alongside each input word
    typedef logic [SEL_W-1:0] ch_sel_t;

endpackage : demux4_pkg

// File: rtl/demux4_buffered_sync_fifo.sv
// Single-clock FIFO holding one output channel's words; head is zero when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full buffer refuses pushes even when it is also popping this cycle
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are don't-care while the matching count is zero
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : sync_fifo

// File: rtl/demux4_buffered.sv
// Routes each input word to one of four buffered output channels chosen by S.
module demux4_buffered
    import demux4_pkg::*;
#(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           d,
    input  ch_sel_t                    S,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           y0,
    output logic [WIDTH-1:0]           y1,
    output logic [WIDTH-1:0]           y2,
    output logic [WIDTH-1:0]           y3,
    output logic                       valid0,
    output logic                       valid1,
    output logic                       valid2,
    output logic                       valid3,
    input  logic                       ready0,
    input  logic                       ready1,
    input  logic                       ready2,
    input  logic                       ready3,
    output logic [$clog2(DEPTH+1)-1:0] count0,
    output logic [$clog2(DEPTH+1)-1:0] count1,
    output logic [$clog2(DEPTH+1)-1:0] count2,
    output logic [$clog2(DEPTH+1)-1:0] count3
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [WIDTH-1:0]  head [NUM_CH];
    logic [CNT_W-1:0]  cnt  [NUM_CH];

    // Acceptance depends only on the selected buffer having room, never on in_valid
    assign in_ready = rst_n & ~full[S];

    assign pop = {ready3, ready2, ready1, ready0};

    // One buffer per channel; push goes only to the channel named by S
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign push[k] = in_valid & in_ready & (S == ch_sel_t'(k));

        sync_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[k]),
            .pop   (pop[k]),
            .din   (d),
            .full  (full[k]),
            .empty (empty[k]),
            .count (cnt[k]),
            .head  (head[k])
        );
    end

    assign y0 = head[0];
    assign y1 = head[1];
    assign y2 = head[2];
    assign y3 = head[3];

    assign valid0 = ~empty[0];
    assign valid1 = ~empty[1];
    assign valid2 = ~empty[2];
    assign valid3 = ~empty[3];

    assign count0 = cnt[0];
    assign count1 = cnt[1];
    assign count2 = cnt[2];
    assign count3 = cnt[3];

endmodule : demux4_buffered

// File: tb/tb_demux4_buffered.sv
// Randomized and directed bench for demux4_buffered with a queue-based scoreboard.
module tb_demux4_buffered;

    localparam int W  = 6;
    localparam int D  = 2;
    localparam int CW = $clog2(D+1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  d = '0;
    logic [1:0]    S = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  y0, y1, y2, y3;
    logic          valid0, valid1, valid2, valid3;
    logic          ready0 = 1'b0, ready1 = 1'b0, ready2 = 1'b0, ready3 = 1'b0;
    logic [CW-1:0] count0, count1, count2, count3;

    demux4_buffered #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .S(S), .in_valid(in_valid), .in_ready(in_ready),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .valid0(valid0), .valid1(valid1), .valid2(valid2), .valid3(valid3),
        .ready0(ready0), .ready1(ready1), .ready2(ready2), .ready3(ready3),
        .count0(count0), .count1(count1), .count2(count2), .count3(count3)
    );

    always #5 clk = ~clk;

    logic [W-1:0] y_a [4];
    logic         v_a [4];
    logic         r_a [4];
    logic [CW-1:0] c_a [4];
    assign y_a[0] = y0; assign y_a[1] = y1; assign y_a[2] = y2; assign y_a[3] = y3;
    assign v_a[0] = valid0; assign v_a[1] = valid1; assign v_a[2] = valid2; assign v_a[3] = valid3;
    assign r_a[0] = ready0; assign r_a[1] = ready1; assign r_a[2] = ready2; assign r_a[3] = ready3;
    assign c_a[0] = count0; assign c_a[1] = count1; assign c_a[2] = count2; assign c_a[3] = count3;

    int           n_checks = 0;
    int           n_fail = 0;
    bit           known = 1'b0;
    int           mcount [4];
    logic [W-1:0] exp_q [4][$];

    task automatic chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every output handshake must deliver the oldest word still owed on that channel
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (v_a[k] && r_a[k]) begin
                    if (exp_q[k].size() == 0) begin
                        chk($sformatf("unexpected_word_ch%0d", k), 1, 0);
                    end else begin
                        chk($sformatf("y%0d_data", k), int'(y_a[k]), int'(exp_q[k].pop_front()));
                    end
                end
            end
        end
    end

    // One clock of stimulus: drive, check occupancy-level outputs, then advance the model at the edge
    task automatic step(input bit rst, input bit v, input int s, input logic [W-1:0] dat,
                        input logic [3:0] rdy, output bit accepted);
        bit acc;
        rst_n = rst; in_valid = v; S = 2'(s); d = dat;
        ready0 = rdy[0]; ready1 = rdy[1]; ready2 = rdy[2]; ready3 = rdy[3];
        @(negedge clk);
        if (known) begin
            chk($sformatf("in_ready_s%0d", s), int'(in_ready), int'(rst && mcount[s] < D));
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("count%0d", k), int'(c_a[k]), mcount[k]);
                chk($sformatf("valid%0d", k), int'(v_a[k]), int'(mcount[k] != 0));
                if (mcount[k] == 0) chk($sformatf("y%0d_empty_zero", k), int'(y_a[k]), 0);
            end
        end
        @(posedge clk);
        acc = 1'b0;
        if (!rst) begin
            known = 1'b1;
            for (int k = 0; k < 4; k++) begin
                mcount[k] = 0;
                exp_q[k].delete();
            end
        end else if (known) begin
            acc = v && (mcount[s] < D);
            for (int k = 0; k < 4; k++) begin
                if (rdy[k] && mcount[k] > 0) mcount[k]--;
            end
            if (acc) begin
                exp_q[s].push_back(dat);
                mcount[s]++;
            end
        end
        accepted = acc;
        #1;
    endtask

    initial begin
        bit acc;
        int idx;
        int total;
        logic [W-1:0] rt_words [4];
        rt_words[0] = 6'h00; rt_words[1] = 6'h01; rt_words[2] = 6'h02; rt_words[3] = 6'h04;
        for (int k = 0; k < 4; k++) mcount[k] = 0;
        #1;

        // Reset held with a word offered: nothing accepted, all outputs idle
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, i, 6'h3F, 4'hF, acc);

        // Routing: one word per channel, consumers always ready
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, i, rt_words[i], 4'hF, acc);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 0, '0, 4'hF, acc);

        // Full on channel 2 blocks only channel 2, then drains in order
        step(1'b1, 1'b1, 2, 6'h11, 4'b1011, acc);
        step(1'b1, 1'b1, 2, 6'h12, 4'b1011, acc);
        step(1'b1, 1'b0, 2, 6'h13, 4'b1011, acc);
        step(1'b1, 1'b0, 0, 6'h13, 4'b1011, acc);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2, '0, 4'hF, acc);

        // Full-with-pop on channel 1: no pass-through, retry accepted next cycle
        step(1'b1, 1'b1, 1, 6'h05, 4'b1101, acc);
        step(1'b1, 1'b1, 1, 6'h06, 4'b1101, acc);
        step(1'b1, 1'b1, 1, 6'h07, 4'b1111, acc);
        chk("full_pop_no_push", int'(acc), 0);
        step(1'b1, 1'b1, 1, 6'h07, 4'b1101, acc);
        chk("full_pop_retry_push", int'(acc), 1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, '0, 4'hF, acc);

        // Wrap: ten words through channel 3 with toggling readiness
        idx = 0;
        for (int cyc = 0; cyc < 60 && idx < 10; cyc++) begin
            step(1'b1, 1'b1, 3, 6'(6'h20 + idx), {cyc[0], 3'b111}, acc);
            if (acc) idx++;
        end
        chk("wrap_all_sent", idx, 10);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, '0, 4'hF, acc);

        // Reset mid-operation discards buffered words on channels 0 and 3
        step(1'b1, 1'b1, 0, 6'h2A, 4'h0, acc);
        step(1'b1, 1'b1, 3, 6'h2B, 4'h0, acc);
        step(1'b1, 1'b1, 0, 6'h2C, 4'h0, acc);
        step(1'b0, 1'b1, 0, 6'h2D, 4'h0, acc);
        step(1'b1, 1'b1, 0, 6'h3E, 4'hF, acc);
        chk("post_reset_first_push", int'(acc), 1);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 0, '0, 4'hF, acc);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 3)), 6'($urandom), 4'($urandom), acc);
        end

        // Drain and confirm nothing is owed
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, '0, 4'hF, acc);
        total = 0;
        for (int k = 0; k < 4; k++) total += exp_q[k].size();
        chk("final_scoreboard_empty", total, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_demux4_buffered
